// File: rtl/zion_write_dat_packer_pkg.sv
// Shared types and helpers for the write-data packer.
// Contents: the packer state enum, the lane-mask function used by the lane
// decoder, and the helpers that check parameters at elaboration.
//
//  state | meaning
//  IDLE  | accumulator empty (mask == 0)
//  FILL  | accumulator partly written, more writes may merge in
//  HOLD  | accumulator closed, waiting for the output register to free
package zion_write_dat_packer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      HOLD = 2'd2
   } packState_e;

   // Upper bound on lanes the mask helper can describe; callers cast down.
   localparam int MASK_MAX = 256;

   // Lanes base .. base+2^size-1 set, everything else clear.
   function automatic logic [MASK_MAX-1:0] laneMask(input int size, input int base);
      logic [MASK_MAX-1:0] m;
      m = '0;
      for (int i = 0; i < MASK_MAX; i++) begin
         m[i] = (i >= base) && (i < base + (1 << size));
      end
      return m;
   endfunction

   function automatic bit isPow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

   function automatic bit addrFits(input int widthAddr, input int unitNum);
      return widthAddr >= $clog2(unitNum);
   endfunction

   // iSize port width; at least one bit even when only one size exists.
   function automatic int sizeWidth(input int sizeMax);
      return (sizeMax > 0) ? $clog2(sizeMax + 1) : 1;
   endfunction

endpackage

// File: rtl/zion_write_lane_decode.sv
// Combinational lane decoder for one narrow write.
// Ports:
//   iAddr  - write address (lane units or size units, see ADDR_TYPE)
//   iSize  - log2 of the write width in lanes
//   iDat   - write data, only the low WIDTH_UNIT<<iSize bits are kept
//   lanes  - lanes touched by the write (all 0 when illegal)
//   datPos - write data placed at its lane position in the wide word
//   illegal- oversized, misaligned or out-of-range write
module zion_write_lane_decode
   import zion_write_dat_packer_pkg::*;
#(
   parameter int WIDTH_UNIT     = 8,
   parameter int WIDTH_DATA_IN  = 32,
   parameter int WIDTH_DATA_OUT = 64,
   parameter int WIDTH_ADDR     = 8,
   parameter int ADDR_TYPE      = 0,
   parameter int UNIT_NUM       = WIDTH_DATA_OUT / WIDTH_UNIT,
   parameter int SIZE_MAX       = $clog2(WIDTH_DATA_IN / WIDTH_UNIT),
   parameter int WIDTH_SIZE     = sizeWidth(SIZE_MAX)
) (
   input  logic [WIDTH_ADDR-1:0]     iAddr,
   input  logic [WIDTH_SIZE-1:0]     iSize,
   input  logic [WIDTH_DATA_IN-1:0]  iDat,
   output logic [UNIT_NUM-1:0]       lanes,
   output logic [WIDTH_DATA_OUT-1:0] datPos,
   output logic                      illegal
);

   int                        sz;
   int                        base;
   logic                      bad;
   logic [WIDTH_DATA_IN-1:0]  datTrim;
   logic [WIDTH_DATA_OUT-1:0] datWide;

   always_comb begin
      sz      = int'(iSize);
      base    = 0;
      bad     = 1'b0;
      datTrim = '0;
      datWide = '0;
      if (sz > SIZE_MAX) begin
         bad = 1'b1;
      end else if (ADDR_TYPE == 0) begin
         base = int'(iAddr) % UNIT_NUM;
         bad  = (base % (1 << sz)) != 0;
      end else begin
         base = int'(iAddr) << sz;
         bad  = base >= UNIT_NUM;
      end
      for (int j = 0; j < WIDTH_DATA_IN; j++) begin
         datTrim[j] = iDat[j] & (j < (WIDTH_UNIT << sz));
      end
      datWide[WIDTH_DATA_IN-1:0] = datTrim;
      illegal = bad;
      if (bad) begin
         lanes  = '0;
         datPos = '0;
      end else begin
         lanes  = UNIT_NUM'(laneMask(sz, base));
         datPos = datWide << (base * WIDTH_UNIT);
      end
   end

endmodule

// File: rtl/zion_write_dat_packer.sv
// Merges narrow addressed writes into a registered wide word with a lane
// mask and hands it downstream on a valid/ready handshake. A word closes when
// all lanes are written, on iLast, or when a new write hits a written lane.
// Ports:
//   clk, rst_n          - clock, async active-low reset
//   iVld/oRdy           - write request handshake (oRdy is combinational)
//   iAddr/iSize/iDat    - write address, log2 lane count, data
//   iLast               - close the word after this write
//   oVld/iRdy           - output word handshake
//   oDat/oMask          - merged word and written-lane mask
//   oErr                - one-cycle pulse after an illegal write is accepted
module zion_write_dat_packer
   import zion_write_dat_packer_pkg::*;
#(
   parameter  int WIDTH_UNIT     = 8,
   parameter  int WIDTH_DATA_IN  = 32,
   parameter  int WIDTH_DATA_OUT = 64,
   parameter  int WIDTH_ADDR     = 8,
   parameter  int ADDR_TYPE      = 0,
   localparam int UNIT_NUM       = WIDTH_DATA_OUT / WIDTH_UNIT,
   localparam int SIZE_MAX       = $clog2(WIDTH_DATA_IN / WIDTH_UNIT),
   localparam int WIDTH_SIZE     = sizeWidth(SIZE_MAX)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      iVld,
   output logic                      oRdy,
   input  logic [WIDTH_ADDR-1:0]     iAddr,
   input  logic [WIDTH_SIZE-1:0]     iSize,
   input  logic [WIDTH_DATA_IN-1:0]  iDat,
   input  logic                      iLast,
   output logic                      oVld,
   input  logic                      iRdy,
   output logic [WIDTH_DATA_OUT-1:0] oDat,
   output logic [UNIT_NUM-1:0]       oMask,
   output logic                      oErr
);

   if (WIDTH_DATA_OUT % WIDTH_DATA_IN != 0) begin : gChkOut
      $error("WIDTH_DATA_OUT must be a multiple of WIDTH_DATA_IN");
   end
   if ((WIDTH_DATA_IN % WIDTH_UNIT != 0) || !isPow2(WIDTH_DATA_IN / WIDTH_UNIT)) begin : gChkIn
      $error("WIDTH_DATA_IN must be WIDTH_UNIT times a power of two");
   end
   if (!addrFits(WIDTH_ADDR, UNIT_NUM)) begin : gChkAddr
      $error("WIDTH_ADDR too narrow for UNIT_NUM lanes");
   end

   logic [UNIT_NUM-1:0]       decLanes;
   logic [WIDTH_DATA_OUT-1:0] decDat;
   logic                      decIllegal;

   zion_write_lane_decode #(
      .WIDTH_UNIT     (WIDTH_UNIT),
      .WIDTH_DATA_IN  (WIDTH_DATA_IN),
      .WIDTH_DATA_OUT (WIDTH_DATA_OUT),
      .WIDTH_ADDR     (WIDTH_ADDR),
      .ADDR_TYPE      (ADDR_TYPE),
      .UNIT_NUM       (UNIT_NUM),
      .SIZE_MAX       (SIZE_MAX),
      .WIDTH_SIZE     (WIDTH_SIZE)
   ) uDecode (
      .iAddr   (iAddr),
      .iSize   (iSize),
      .iDat    (iDat),
      .lanes   (decLanes),
      .datPos  (decDat),
      .illegal (decIllegal)
   );

   packState_e                state, stateNxt;
   logic [WIDTH_DATA_OUT-1:0] accDat;
   logic [UNIT_NUM-1:0]       accMask;
   logic                      collision, accept, takeWrite, outFree, closeWord;
   logic [WIDTH_DATA_OUT-1:0] mergeDat;
   logic [UNIT_NUM-1:0]       mergeMask;
   logic                      loadOut, clearAcc, updAcc;

   assign collision = iVld && (state != HOLD) && !decIllegal && |(decLanes & accMask);
   assign oRdy      = (state != HOLD) && !collision;
   assign accept    = iVld && oRdy;
   assign takeWrite = accept && !decIllegal;
   assign mergeMask = takeWrite ? (accMask | decLanes) : accMask;
   assign mergeDat  = takeWrite ? (accDat | decDat) : accDat;
   assign outFree   = !oVld || iRdy;
   // A collision closes the current word without the colliding write.
   assign closeWord = (takeWrite && ((&mergeMask) || iLast)) || collision;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= stateNxt;
   end

   // In HOLD no write is taken, so mergeDat/mergeMask equal the held word.
   always_comb begin
      stateNxt = state;
      loadOut  = 1'b0;
      clearAcc = 1'b0;
      updAcc   = 1'b0;
      case (state)
         HOLD: begin
            if (outFree) begin
               loadOut  = 1'b1;
               clearAcc = 1'b1;
               stateNxt = IDLE;
            end
         end
         default: begin
            if (closeWord) begin
               if (outFree) begin
                  loadOut  = 1'b1;
                  clearAcc = 1'b1;
                  stateNxt = IDLE;
               end else begin
                  updAcc   = 1'b1;
                  stateNxt = HOLD;
               end
            end else if (takeWrite) begin
               updAcc   = 1'b1;
               stateNxt = FILL;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         accDat  <= '0;
         accMask <= '0;
         oVld    <= 1'b0;
         oDat    <= '0;
         oMask   <= '0;
         oErr    <= 1'b0;
      end else begin
         if (clearAcc) begin
            accDat  <= '0;
            accMask <= '0;
         end else if (updAcc) begin
            accDat  <= mergeDat;
            accMask <= mergeMask;
         end
         if (loadOut) begin
            oVld  <= 1'b1;
            oDat  <= mergeDat;
            oMask <= mergeMask;
         end else if (iRdy) begin
            oVld  <= 1'b0;
         end
         oErr <= accept && decIllegal;
      end
   end

endmodule

// File: tb/tb_zion_write_dat_packer.sv
module tb_zion_write_dat_packer;
   import zion_write_dat_packer_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   always #5 clk = ~clk;

   // DUT A: lane addressing
   logic        iVld, oRdy, iLast, oVld, iRdy, oErr;
   logic [7:0]  iAddr;
   logic [1:0]  iSize;
   logic [31:0] iDat, oDat;
   logic [3:0]  oMask;

   // DUT B: size-unit addressing
   logic        iVldB, oRdyB, iLastB, oVldB, iRdyB, oErrB;
   logic [7:0]  iAddrB;
   logic [1:0]  iSizeB;
   logic [31:0] iDatB, oDatB;
   logic [3:0]  oMaskB;

   zion_write_dat_packer #(
      .WIDTH_UNIT(8), .WIDTH_DATA_IN(32), .WIDTH_DATA_OUT(32),
      .WIDTH_ADDR(8), .ADDR_TYPE(0)
   ) dutA (
      .clk(clk), .rst_n(rst_n), .iVld(iVld), .oRdy(oRdy), .iAddr(iAddr),
      .iSize(iSize), .iDat(iDat), .iLast(iLast), .oVld(oVld), .iRdy(iRdy),
      .oDat(oDat), .oMask(oMask), .oErr(oErr)
   );

   zion_write_dat_packer #(
      .WIDTH_UNIT(8), .WIDTH_DATA_IN(32), .WIDTH_DATA_OUT(32),
      .WIDTH_ADDR(8), .ADDR_TYPE(1)
   ) dutB (
      .clk(clk), .rst_n(rst_n), .iVld(iVldB), .oRdy(oRdyB), .iAddr(iAddrB),
      .iSize(iSizeB), .iDat(iDatB), .iLast(iLastB), .oVld(oVldB), .iRdy(iRdyB),
      .oDat(oDatB), .oMask(oMaskB), .oErr(oErrB)
   );

   typedef struct {
      logic        vld;
      logic [7:0]  addr;
      logic [1:0]  size;
      logic [31:0] dat;
      logic        last;
      logic        rdy;
      logic        expORdy;
      logic        expOVld;
      logic [31:0] expDat;
      logic [3:0]  expMask;
      logic        expErr;
      packState_e  expState;
   } vec_t;

   localparam int NVEC = 20;
   vec_t vecs[NVEC];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic vld, input logic [7:0] addr, input logic [1:0] size,
                               input logic [31:0] dat, input logic last, input logic rdy,
                               input logic eRdy, input logic eVld, input logic [31:0] eDat,
                               input logic [3:0] eMask, input logic eErr, input packState_e eSt);
      vec_t v;
      v.vld = vld; v.addr = addr; v.size = size; v.dat = dat; v.last = last; v.rdy = rdy;
      v.expORdy = eRdy; v.expOVld = eVld; v.expDat = eDat; v.expMask = eMask;
      v.expErr = eErr; v.expState = eSt;
      return v;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   initial begin
      //           vld addr  sz dat            lst rdy  oRdy  oVld oDat          oMask  err state
      vecs[0]  = mk(1, 8'd0, 0, 32'h11,        0, 1,   1,    0, 32'h0,        4'h0,  0, FILL);
      vecs[1]  = mk(1, 8'd1, 0, 32'h22,        0, 1,   1,    0, 32'h0,        4'h0,  0, FILL);
      vecs[2]  = mk(1, 8'd2, 0, 32'h33,        0, 1,   1,    0, 32'h0,        4'h0,  0, FILL);
      vecs[3]  = mk(1, 8'd3, 0, 32'h44,        0, 1,   1,    1, 32'h44332211, 4'hF,  0, IDLE);
      vecs[4]  = mk(1, 8'd2, 1, 32'hBEEF,      1, 1,   1,    1, 32'hBEEF0000, 4'hC,  0, IDLE);
      vecs[5]  = mk(1, 8'd1, 0, 32'hAA,        0, 1,   1,    0, 32'h0,        4'h0,  0, FILL);
      vecs[6]  = mk(1, 8'd1, 0, 32'hBB,        0, 1,   0,    1, 32'h0000AA00, 4'h2,  0, IDLE);
      vecs[7]  = mk(1, 8'd1, 0, 32'hBB,        0, 1,   1,    0, 32'h0,        4'h0,  0, FILL);
      vecs[8]  = mk(1, 8'd0, 0, 32'h01,        1, 1,   1,    1, 32'h0000BB01, 4'h3,  0, IDLE);
      vecs[9]  = mk(1, 8'd0, 1, 32'hCAFE,      1, 0,   1,    1, 32'h0000BB01, 4'h3,  0, HOLD);
      vecs[10] = mk(1, 8'd2, 0, 32'h77,        0, 0,   0,    1, 32'h0000BB01, 4'h3,  0, HOLD);
      vecs[11] = mk(1, 8'd2, 0, 32'h77,        0, 1,   0,    1, 32'h0000CAFE, 4'h3,  0, IDLE);
      vecs[12] = mk(1, 8'd2, 0, 32'h77,        1, 1,   1,    1, 32'h00770000, 4'h4,  0, IDLE);
      vecs[13] = mk(1, 8'd1, 1, 32'h1234,      1, 1,   1,    0, 32'h0,        4'h0,  1, IDLE);
      vecs[14] = mk(0, 8'd0, 0, 32'h0,         0, 1,   1,    0, 32'h0,        4'h0,  0, IDLE);
      vecs[15] = mk(1, 8'd0, 0, 32'h55,        0, 1,   1,    0, 32'h0,        4'h0,  0, FILL);
      vecs[16] = mk(1, 8'd0, 3, 32'h99999999,  1, 1,   1,    0, 32'h0,        4'h0,  1, FILL);
      vecs[17] = mk(0, 8'd0, 0, 32'h0,         0, 1,   1,    0, 32'h0,        4'h0,  0, FILL);
      vecs[18] = mk(1, 8'd1, 0, 32'h66,        1, 1,   1,    1, 32'h00006655, 4'h3,  0, IDLE);
      vecs[19] = mk(0, 8'd0, 0, 32'h0,         0, 1,   1,    0, 32'h0,        4'h0,  0, IDLE);

      rst_n = 1'b0;
      iVld = 0; iAddr = 0; iSize = 0; iDat = 0; iLast = 0; iRdy = 1;
      iVldB = 0; iAddrB = 0; iSizeB = 0; iDatB = 0; iLastB = 0; iRdyB = 1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_oVld",  32'(oVld),  32'h0);
      check("rst_oDat",  oDat,       32'h0);
      check("rst_oMask", 32'(oMask), 32'h0);
      check("rst_oErr",  32'(oErr),  32'h0);
      check("rst_state", 32'(dutA.state), 32'(IDLE));
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_oRdy", 32'(oRdy), 32'h1);

      for (int i = 0; i < NVEC; i++) begin
         iVld = vecs[i].vld; iAddr = vecs[i].addr; iSize = vecs[i].size;
         iDat = vecs[i].dat; iLast = vecs[i].last; iRdy = vecs[i].rdy;
         #1;
         check($sformatf("v%0d_oRdy", i), 32'(oRdy), 32'(vecs[i].expORdy));
         @(posedge clk); #1;
         check($sformatf("v%0d_oVld", i), 32'(oVld), 32'(vecs[i].expOVld));
         if (vecs[i].expOVld) begin
            check($sformatf("v%0d_oDat", i),  oDat,       vecs[i].expDat);
            check($sformatf("v%0d_oMask", i), 32'(oMask), 32'(vecs[i].expMask));
         end
         check($sformatf("v%0d_oErr", i),  32'(oErr),  32'(vecs[i].expErr));
         check($sformatf("v%0d_state", i), 32'(dutA.state), 32'(vecs[i].expState));
      end

      // Reset in the middle of a fill discards the partial word.
      iVld = 1; iAddr = 8'd0; iSize = 2'd1; iDat = 32'h1234; iLast = 0; iRdy = 1;
      @(posedge clk); #1;
      iVld = 0;
      check("mid_accMask", 32'(dutA.accMask), 32'h3);
      rst_n = 1'b0;
      #1;
      check("midrst_oVld",  32'(oVld),  32'h0);
      check("midrst_oDat",  oDat,       32'h0);
      check("midrst_oMask", 32'(oMask), 32'h0);
      check("midrst_oErr",  32'(oErr),  32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      iVld = 1; iAddr = 8'd0; iSize = 2'd0; iDat = 32'h5A; iLast = 1;
      #1;
      check("after_rst_oRdy", 32'(oRdy), 32'h1);
      @(posedge clk); #1;
      iVld = 0; iLast = 0;
      check("after_rst_oVld",  32'(oVld),  32'h1);
      check("after_rst_oMask", 32'(oMask), 32'h1);
      check("after_rst_oDat",  oDat,       32'h0000005A);

      // Size-unit addressing: word at index 1 is out of range, halfword at 1 is lanes 2..3.
      iVldB = 1; iAddrB = 8'd1; iSizeB = 2'd2; iDatB = 32'hDEADBEEF; iLastB = 1;
      #1;
      check("B_illegal_oRdy", 32'(oRdyB), 32'h1);
      @(posedge clk); #1;
      check("B_illegal_oErr", 32'(oErrB), 32'h1);
      check("B_illegal_oVld", 32'(oVldB), 32'h0);
      iAddrB = 8'd1; iSizeB = 2'd1; iDatB = 32'h0000F00D; iLastB = 1;
      @(posedge clk); #1;
      iVldB = 0; iLastB = 0;
      check("B_legal_oErr",  32'(oErrB),  32'h0);
      check("B_legal_oVld",  32'(oVldB),  32'h1);
      check("B_legal_oDat",  oDatB,       32'hF00D0000);
      check("B_legal_oMask", 32'(oMaskB), 32'hC);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
